bip_debug_unit: RTL and testbench

Debug/loader controller sitting between the board UART and the BIP core. It decodes single-byte commands, writes program words into instruction memory, and sequences the core through free-run or single-step execution by gating its clock enable. After each load, run or step it returns a byte report over the UART transmitter. It is the only block that drives the core enable and the instruction-memory write port.

---
 rtl/bip_debug_unit.sv | 184 ++++++++++++++++++
 tb/tb_bip_debug_unit.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bip_debug_unit.sv
// bip_debug_unit: UART-driven loader and run/step sequencer for the BIP core.
// Decodes 'L' (load program), 'R' (free run until halt) and 'S' (single step)
// command bytes, owns the instruction-memory write port and the core clock
// enable, and returns a byte report over the UART transmitter after each
// command: 'K' after a load, {PC, ACC, cycle count} after a run or step.
module bip_debug_unit #(
  parameter int NB_BITS       = 16,
  parameter int INS_MEM_DEPTH = 2048,
  localparam int NB_ADDR      = $clog2(INS_MEM_DEPTH)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [7:0]         i_rx_data,
  input  logic               i_rx_valid,
  input  logic               i_tx_done,
  input  logic               i_halt,
  input  logic [NB_ADDR-1:0] i_pc,
  input  logic [NB_BITS-1:0] i_acc,
  output logic [7:0]         o_tx_data,
  output logic               o_tx_start,
  output logic               o_cpu_en,
  output logic               o_cpu_rst,
  output logic               o_prog_we,
  output logic [NB_ADDR-1:0] o_prog_addr,
  output logic [NB_BITS-1:0] o_prog_data,
  output logic               o_busy
);

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_RUN  = 8'h52;
  localparam logic [7:0] CMD_STEP = 8'h53;
  localparam logic [7:0] RPT_OK   = 8'h4B;
  localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(INS_MEM_DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD_HI, LOAD_LO, WRITE, RUN, STEP, SEND, WAIT_TX
  } state_t;

  state_t              state_q, state_d;
  logic [NB_ADDR-1:0]  addr_q;
  logic [NB_BITS-1:0]  word_q;
  logic [15:0]         count_q;
  logic [2:0]          idx_q;
  logic [2:0]          last_q;
  logic [7:0]          rpt_q [0:5];

  logic                cpu_en;
  logic                cpu_rst;
  logic                prog_we;
  logic                tx_start;
  logic                load_done;
  logic                last_byte;
  logic                snap_en;
  logic [15:0]         count_step;
  logic [15:0]         snap_cnt;
  logic [15:0]         pc16;

  // Cycle counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign load_done  = (word_q == '0) || (addr_q == LAST_ADDR);
  assign last_byte  = (idx_q == last_q);
  assign count_step = cpu_en ? sat_inc(count_q) : count_q;
  assign snap_en    = ((state_q == RUN) && i_halt) || (state_q == STEP);
  assign snap_cnt   = (state_q == STEP) ? count_step : count_q;
  assign pc16       = 16'(i_pc);

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode and per-state control strobes.
  always_comb begin
    state_d  = state_q;
    cpu_en   = 1'b0;
    cpu_rst  = 1'b0;
    prog_we  = 1'b0;
    tx_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_rx_valid) begin
          if (i_rx_data == CMD_LOAD)      state_d = LOAD_HI;
          else if (i_rx_data == CMD_RUN)  state_d = RUN;
          else if (i_rx_data == CMD_STEP) state_d = STEP;
        end
      end
      LOAD_HI: begin
        cpu_rst = 1'b1;
        if (i_rx_valid) state_d = LOAD_LO;
      end
      LOAD_LO: begin
        cpu_rst = 1'b1;
        if (i_rx_valid) state_d = WRITE;
      end
      WRITE: begin
        cpu_rst = 1'b1;
        prog_we = 1'b1;
        state_d = load_done ? SEND : LOAD_HI;
      end
      RUN: begin
        cpu_en = ~i_halt;
        if (i_halt) state_d = SEND;
      end
      STEP: begin
        cpu_en  = ~i_halt;
        state_d = SEND;
      end
      SEND: begin
        tx_start = 1'b1;
        state_d  = WAIT_TX;
      end
      WAIT_TX: begin
        if (i_tx_done) state_d = last_byte ? IDLE : SEND;
      end
      default: state_d = IDLE;
    endcase
  end

  // Load address/word, cycle counter and report buffer bookkeeping.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      addr_q  <= '0;
      word_q  <= '0;
      count_q <= '0;
      idx_q   <= '0;
      last_q  <= '0;
      for (int i = 0; i < 6; i++) rpt_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_rx_valid) begin
            if (i_rx_data == CMD_LOAD) begin
              addr_q  <= '0;
              count_q <= '0;
            end else if (i_rx_data == CMD_RUN) begin
              count_q <= '0;
            end
          end
        end
        LOAD_HI: if (i_rx_valid) word_q[15:8] <= i_rx_data;
        LOAD_LO: if (i_rx_valid) word_q[7:0]  <= i_rx_data;
        WRITE: begin
          // Hold at the last word rather than wrap onto address 0.
          if (addr_q != LAST_ADDR) addr_q <= addr_q + NB_ADDR'(1);
          if (load_done) begin
            rpt_q[0] <= RPT_OK;
            idx_q    <= '0;
            last_q   <= '0;
          end
        end
        RUN:     if (cpu_en) count_q <= sat_inc(count_q);
        STEP:    count_q <= count_step;
        WAIT_TX: if (i_tx_done && !last_byte) idx_q <= idx_q + 3'd1;
        default: ;
      endcase
      // Report snapshot is taken on the edge that enters SEND, so a step
      // reports the PC/ACC the core held while the step was enabled.
      if (snap_en) begin
        rpt_q[0] <= pc16[15:8];
        rpt_q[1] <= pc16[7:0];
        rpt_q[2] <= i_acc[15:8];
        rpt_q[3] <= i_acc[7:0];
        rpt_q[4] <= snap_cnt[15:8];
        rpt_q[5] <= snap_cnt[7:0];
        idx_q    <= '0;
        last_q   <= 3'd5;
      end
    end
  end

  assign o_tx_data   = rpt_q[idx_q];
  assign o_tx_start  = tx_start;
  assign o_cpu_en    = cpu_en;
  assign o_cpu_rst   = cpu_rst;
  assign o_prog_we   = prog_we;
  assign o_prog_addr = addr_q;
  assign o_prog_data = word_q;
  assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_bip_debug_unit.sv
// tb_bip_debug_unit: randomized scoreboard bench for bip_debug_unit.
// A small BIP core/instruction-memory model provides i_halt/i_pc/i_acc; a
// transaction-level reference executes loaded programs directly to predict
// write strobes and report bytes, which a negedge monitor pops and compares.
module tb_bip_debug_unit;
  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          tx_done = 1'b0;
  logic          halt;
  logic [AW-1:0] pc;
  logic [15:0]   acc;
  logic [7:0]    tx_data;
  logic          tx_start, cpu_en, cpu_rst, prog_we, busy;
  logic [AW-1:0] prog_addr;
  logic [15:0]   prog_data;

  bip_debug_unit #(.NB_BITS(16), .INS_MEM_DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .i_tx_done(tx_done), .i_halt(halt), .i_pc(pc), .i_acc(acc),
    .o_tx_data(tx_data), .o_tx_start(tx_start), .o_cpu_en(cpu_en),
    .o_cpu_rst(cpu_rst), .o_prog_we(prog_we), .o_prog_addr(prog_addr),
    .o_prog_data(prog_data), .o_busy(busy)
  );

  always #5 clk = ~clk;

  // ISA subset: 00011 LDI (acc = sext imm), 00101 ADDI (acc += sext imm), 00000 HLT.
  function automatic logic [15:0] isa_acc(input logic [15:0] ins, input logic [15:0] a);
    logic [15:0] imm;
    imm = {{5{ins[10]}}, ins[10:0]};
    case (ins[15:11])
      5'd3:    return imm;
      5'd5:    return a + imm;
      default: return a;
    endcase
  endfunction

  // Core + instruction memory environment.
  logic [15:0]   imem [DEPTH];
  logic [AW-1:0] core_pc;
  logic [15:0]   core_acc;
  always @(posedge clk) begin
    if (rst) for (int i = 0; i < DEPTH; i++) imem[i] <= '0;
    else if (prog_we) imem[prog_addr] <= prog_data;
    if (rst || cpu_rst) begin
      core_pc  <= '0;
      core_acc <= '0;
    end else if (cpu_en) begin
      core_pc  <= core_pc + 1'b1;
      core_acc <= isa_acc(imem[core_pc], core_acc);
    end
  end
  assign halt = (imem[core_pc][15:11] == 5'd0);
  assign pc   = core_pc;
  assign acc  = core_acc;

  // Reference state and scoreboard.
  logic [15:0]   ref_mem [DEPTH];
  logic [AW-1:0] ref_pc;
  logic [15:0]   ref_acc, ref_cnt;
  logic [7:0]    exp_tx[$];
  logic [20:0]   exp_wr[$];
  logic [15:0]   prog[$];
  int total = 0, bad = 0, en_cnt = 0, tx_delay = 2;
  bit spur = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic ref_reset();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    ref_pc = '0; ref_acc = '0; ref_cnt = '0;
  endtask

  task automatic ref_step();
    ref_acc = isa_acc(ref_mem[ref_pc], ref_acc);
    ref_pc  = ref_pc + 1'b1;
    if (ref_cnt != 16'hFFFF) ref_cnt = ref_cnt + 16'd1;
  endtask

  task automatic push_report(input logic [AW-1:0] p, input logic [15:0] a, input logic [15:0] c);
    exp_tx.push_back(8'h00);
    exp_tx.push_back({3'b000, p});
    exp_tx.push_back(a[15:8]);
    exp_tx.push_back(a[7:0]);
    exp_tx.push_back(c[15:8]);
    exp_tx.push_back(c[7:0]);
  endtask

  // Monitor: pops expectations whenever the DUT presents a write or tx byte.
  initial begin
    logic [20:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (cpu_en) en_cnt++;
        if (tx_start) begin
          if (exp_tx.size() == 0) begin
            total++; bad++;
            $display("FAIL tx_unexpected: got byte %0h, required no transmit", tx_data);
          end else chk("tx_byte", tx_data, exp_tx.pop_front());
        end
        if (prog_we) begin
          chk("wr_cpu_rst", cpu_rst, 1);
          if (exp_wr.size() == 0) begin
            total++; bad++;
            $display("FAIL wr_unexpected: got addr %0h data %0h, required no write", prog_addr, prog_data);
          end else begin
            e = exp_wr.pop_front();
            chk("wr_addr", prog_addr, e[20:16]);
            chk("wr_data", prog_data, e[15:0]);
          end
        end
      end
    end
  end

  // UART transmitter stand-in: optional early done in the start cycle, then
  // tx_delay cycles later a real done; data must hold across the wait.
  initial begin
    logic [7:0] held;
    forever begin
      @(negedge clk);
      tx_done = 1'b0;
      if (tx_start && !rst) begin
        held = tx_data;
        if (spur) begin
          tx_done = 1'b1;
          @(negedge clk);
          tx_done = 1'b0;
        end
        repeat (tx_delay) @(negedge clk);
        chk("tx_hold", tx_data, held);
        tx_done = 1'b1;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 3000);
    chk("idle_timeout", busy, 0);
    chk("tx_drained", exp_tx.size(), 0);
    chk("wr_drained", exp_wr.size(), 0);
  endtask

  task automatic load_prog();
    exp_tx.push_back(8'h4B);
    ref_pc = '0; ref_acc = '0; ref_cnt = '0;
    send_byte(8'h4C);
    foreach (prog[i]) begin
      exp_wr.push_back({AW'(i), prog[i]});
      ref_mem[i] = prog[i];
      send_byte(prog[i][15:8]);
      send_byte(prog[i][7:0]);
      if (prog[i] == 16'h0000 || i == DEPTH - 1) break;
    end
    wait_idle();
  endtask

  task automatic run_cmd(input bit inject);
    int e0, en_exp;
    en_exp = 0;
    ref_cnt = '0;
    while (ref_mem[ref_pc][15:11] != 5'd0 && en_exp < 1000) begin
      ref_step();
      en_exp++;
    end
    push_report(ref_pc, ref_acc, ref_cnt);
    e0 = en_cnt;
    send_byte(8'h52);
    if (inject) begin
      send_byte(8'h52);
      send_byte(8'h41);
    end
    wait_idle();
    chk("run_en_cycles", en_cnt - e0, en_exp);
  endtask

  task automatic step_cmd();
    int e0, en_exp;
    logic [AW-1:0] p0;
    logic [15:0] a0;
    p0 = ref_pc; a0 = ref_acc;
    en_exp = (ref_mem[ref_pc][15:11] != 5'd0) ? 1 : 0;
    if (en_exp != 0) ref_step();
    push_report(p0, a0, ref_cnt);
    e0 = en_cnt;
    send_byte(8'h53);
    wait_idle();
    chk("step_en_cycles", en_cnt - e0, en_exp);
  endtask

  task automatic check_abort(input string tag);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_cpu_en"}, cpu_en, 0);
    chk({tag, "_prog_we"}, prog_we, 0);
    chk({tag, "_tx_start"}, tx_start, 0);
    rst = 1'b0;
    ref_reset();
    repeat (12) @(negedge clk);
    chk({tag, "_still_idle"}, busy, 0);
  endtask

  // Global time bound.
  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    ref_reset();
    repeat (3) @(negedge clk);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_cpu_en", cpu_en, 0);
    chk("rst_cpu_rst", cpu_rst, 0);
    chk("rst_prog_we", prog_we, 0);
    chk("rst_prog_addr", prog_addr, 0);
    chk("rst_prog_data", prog_data, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;

    // Run with halt at PC 0: no enable, all-zero report.
    run_cmd(1'b0);

    // Non-command bytes in IDLE are ignored.
    for (int k = 0; k < 8; k++) begin
      do b = 8'($urandom_range(0, 255)); while (b == 8'h4C || b == 8'h52 || b == 8'h53);
      if (k == 0) b = 8'h41;
      send_byte(b);
      chk("junk_idle", busy, 0);
    end

    // Directed program: LDI 5, ADDI 3, HLT.
    prog = '{16'h1805, 16'h2803, 16'h0000};
    load_prog();
    run_cmd(1'b1);

    // Two single steps from a freshly reset core.
    load_prog();
    step_cmd();
    step_cmd();

    // Slow transmitter with early done strobes.
    tx_delay = 20; spur = 1'b1;
    run_cmd(1'b1);
    step_cmd();

    // Randomized programs and command mixes.
    for (int it = 0; it < 6; it++) begin
      int len;
      len = $urandom_range(1, 6);
      prog = {};
      for (int j = 0; j < len; j++)
        prog.push_back({($urandom_range(0, 1) != 0) ? 5'd3 : 5'd5, 11'($urandom)});
      prog.push_back(16'h0000);
      tx_delay = $urandom_range(1, 6);
      spur = 1'($urandom_range(0, 1));
      load_prog();
      for (int j = 0; j < 3; j++) begin
        if ($urandom_range(0, 1) != 0) run_cmd(1'($urandom_range(0, 1)));
        else step_cmd();
      end
    end

    // Full memory with no halt word: load stops at the last address.
    tx_delay = 2; spur = 1'b0;
    prog = {};
    for (int j = 0; j < DEPTH; j++) prog.push_back({5'd5, 11'(j + 1)});
    load_prog();

    // Reset during RUN.
    prog = {};
    for (int j = 0; j < 24; j++) prog.push_back(16'h2801);
    prog.push_back(16'h0000);
    load_prog();
    send_byte(8'h52);
    repeat (3) @(negedge clk);
    chk("abort_run_active", cpu_en, 1);
    check_abort("abort_run");

    // Reset during LOAD_LO.
    send_byte(8'h4C);
    send_byte(8'h12);
    chk("abort_load_cpu_rst", cpu_rst, 1);
    check_abort("abort_load");

    // After reset the memory is empty again: zero reports, no enable.
    run_cmd(1'b0);
    step_cmd();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
